// File: rtl/ibm_sched.sv
// ibm_sched: job scheduler feeding syndrome sets to the ibm key-equation solver
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_syn_valid/o_syn_ready           syndrome set handshake into 1-entry staging
//   i_syn_mode/i_syn_code/i_syn_S     set tags and {S8..S1}
//   o_ibm_clear_and_wen/mode/code/S   ibm load pulse and operands
//   i_ibm_valid/i_ibm_sigma           ibm result pulse and packed sigma
//   o_out_valid/i_out_ready           result handshake toward Chien search
//   o_out_sigma/mode/code/zero        result data, tags, all-zero bypass flag
//   o_err                             one-cycle pulse on ibm timeout abort
module ibm_sched #(
    parameter int SYM_W   = 10,
    parameter int TIMEOUT = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_syn_valid,
    output logic               o_syn_ready,
    input  logic               i_syn_mode,
    input  logic [1:0]         i_syn_code,
    input  logic [8*SYM_W-1:0] i_syn_S,
    output logic               o_ibm_clear_and_wen,
    output logic               o_ibm_mode,
    output logic [1:0]         o_ibm_code,
    output logic [8*SYM_W-1:0] o_ibm_S,
    input  logic               i_ibm_valid,
    input  logic [8*SYM_W-1:0] i_ibm_sigma,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [8*SYM_W-1:0] o_out_sigma,
    output logic               o_out_mode,
    output logic [1:0]         o_out_code,
    output logic               o_out_zero,
    output logic               o_err
);
    localparam int SW = 8*SYM_W;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state_q, state_d;
    logic stg_full_q, stg_full_d, stg_mode_q, stg_mode_d, job_mode_q, job_mode_d;
    logic [1:0] stg_code_q, stg_code_d, job_code_q, job_code_d;
    logic [SW-1:0] stg_s_q, stg_s_d;
    logic [3:0] timer_q, timer_d;
    logic out_valid_q, out_valid_d, out_mode_q, out_mode_d, out_zero_q, out_zero_d;
    logic [1:0] out_code_q, out_code_d;
    logic [SW-1:0] out_sigma_q, out_sigma_d;
    logic stg_zero, out_free, clear, pop, wr, wr_zero, done, err;
    logic [SW-1:0] bypass_sigma;
    always_comb begin
        stg_zero = (stg_code_q != 2'b10 && !stg_mode_q) ? ~|stg_s_q[4*SYM_W-1:0] : ~|stg_s_q;
        bypass_sigma = SW'(1) | ((stg_mode_q && stg_code_q != 2'b10) ? (SW'(1) << (5*SYM_W)) : '0);
        out_free = !out_valid_q || i_out_ready;
        state_d = state_q;
        stg_full_d = stg_full_q;
        stg_mode_d = stg_mode_q;
        stg_code_d = stg_code_q;
        stg_s_d = stg_s_q;
        job_mode_d = job_mode_q;
        job_code_d = job_code_q;
        timer_d = timer_q;
        out_valid_d = out_valid_q;
        out_sigma_d = out_sigma_q;
        out_mode_d = out_mode_q;
        out_code_d = out_code_q;
        out_zero_d = out_zero_q;
        clear = 1'b0;
        pop = 1'b0;
        wr = 1'b0;
        wr_zero = 1'b0;
        done = 1'b0;
        err = 1'b0;
        case (state_q)
            IDLE: begin
                if (stg_full_q && !stg_zero) clear = 1'b1;
                else if (stg_full_q && out_free) begin
                    wr = 1'b1;
                    wr_zero = 1'b1;
                    pop = 1'b1;
                end
            end
            RUN: begin
                if (i_ibm_valid) begin
                    if (out_free) done = 1'b1;
                    else state_d = HOLD;
                end else if (timer_q == 4'(TIMEOUT)) begin
                    err = 1'b1;
                    state_d = IDLE;
                end else timer_d = timer_q + 4'd1;
            end
            HOLD: done = out_free;
            default: state_d = IDLE;
        endcase
        // Capturing a result immediately chains the next nonzero job; zero jobs go via IDLE to keep order
        if (done) begin
            wr = 1'b1;
            state_d = IDLE;
            clear = stg_full_q && !stg_zero;
        end
        // Timer starts at 1 so it equals cycles elapsed since the clear pulse
        if (clear) begin
            pop = 1'b1;
            job_mode_d = stg_mode_q;
            job_code_d = stg_code_q;
            timer_d = 4'd1;
            state_d = RUN;
        end
        if (pop) stg_full_d = 1'b0;
        if (i_syn_valid && !stg_full_q) begin
            stg_full_d = 1'b1;
            stg_mode_d = i_syn_mode;
            stg_code_d = i_syn_code;
            stg_s_d = i_syn_S;
        end
        if (i_out_ready) out_valid_d = 1'b0;
        if (wr) begin
            out_valid_d = 1'b1;
            out_sigma_d = wr_zero ? bypass_sigma : i_ibm_sigma;
            out_mode_d = wr_zero ? stg_mode_q : job_mode_q;
            out_code_d = wr_zero ? stg_code_q : job_code_q;
            out_zero_d = wr_zero;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            stg_full_q <= 1'b0;
            stg_mode_q <= 1'b0;
            stg_code_q <= '0;
            stg_s_q <= '0;
            job_mode_q <= 1'b0;
            job_code_q <= '0;
            timer_q <= '0;
            out_valid_q <= 1'b0;
            out_sigma_q <= '0;
            out_mode_q <= 1'b0;
            out_code_q <= '0;
            out_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_full_q <= stg_full_d;
            stg_mode_q <= stg_mode_d;
            stg_code_q <= stg_code_d;
            stg_s_q <= stg_s_d;
            job_mode_q <= job_mode_d;
            job_code_q <= job_code_d;
            timer_q <= timer_d;
            out_valid_q <= out_valid_d;
            out_sigma_q <= out_sigma_d;
            out_mode_q <= out_mode_d;
            out_code_q <= out_code_d;
            out_zero_q <= out_zero_d;
        end
    end
    assign o_syn_ready = !stg_full_q;
    assign o_ibm_clear_and_wen = clear;
    assign o_ibm_mode = clear ? stg_mode_q : job_mode_q;
    assign o_ibm_code = clear ? stg_code_q : job_code_q;
    assign o_ibm_S = stg_s_q;
    assign o_out_valid = out_valid_q;
    assign o_out_sigma = out_sigma_q;
    assign o_out_mode = out_mode_q;
    assign o_out_code = out_code_q;
    assign o_out_zero = out_zero_q;
    assign o_err = err;
endmodule

// File: tb/tb_ibm_sched.sv
// tb_ibm_sched: randomized self-checking bench for ibm_sched with an ibm stub and result scoreboard
module tb_ibm_sched;
    localparam int W = 10;
    localparam int SW = 8*W;
    localparam int VW = SW+4;
    typedef struct {
        logic mode;
        logic [1:0] code;
        logic [SW-1:0] s;
        logic [SW-1:0] sig;
    } job_t;
    logic i_clk = 1'b0;
    logic i_rst, i_syn_valid, o_syn_ready, i_syn_mode, o_ibm_clear_and_wen, o_ibm_mode;
    logic i_ibm_valid, o_out_valid, i_out_ready, o_out_mode, o_out_zero, o_err;
    logic [1:0] i_syn_code, o_ibm_code, o_out_code;
    logic [SW-1:0] i_syn_S, o_ibm_S, i_ibm_sigma, o_out_sigma;
    always #5 i_clk = ~i_clk;
    ibm_sched #(.SYM_W(W), .TIMEOUT(12)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_syn_valid(i_syn_valid), .o_syn_ready(o_syn_ready),
        .i_syn_mode(i_syn_mode), .i_syn_code(i_syn_code), .i_syn_S(i_syn_S),
        .o_ibm_clear_and_wen(o_ibm_clear_and_wen), .o_ibm_mode(o_ibm_mode),
        .o_ibm_code(o_ibm_code), .o_ibm_S(o_ibm_S),
        .i_ibm_valid(i_ibm_valid), .i_ibm_sigma(i_ibm_sigma),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_sigma(o_out_sigma), .o_out_mode(o_out_mode), .o_out_code(o_out_code),
        .o_out_zero(o_out_zero), .o_err(o_err)
    );
    job_t feed[$], issueq[$];
    logic [VW-1:0] expq[$];
    int due[$];
    logic [SW-1:0] dsig[$];
    int clrs[$], pops[$];
    int cyc = 0, checks = 0, errors = 0;
    int hs_cyc = 0, rise_cyc = 0, err_cyc = -1;
    int rdy_pct = 100, feed_pct = 100;
    bit stub_dead = 0, rst_req = 1, saw_busy = 0, prev_outv = 0;
    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic bit is_zero(job_t j);
        int n;
        n = (j.code != 2'b10 && !j.mode) ? 4 : 8;
        for (int i = 0; i < n; i++) if (j.s[i*W +: W] != '0) return 1'b0;
        return 1'b1;
    endfunction
    function automatic logic [VW-1:0] expect_of(job_t j);
        logic [SW-1:0] sig;
        if (!is_zero(j)) return {j.sig, j.mode, j.code, 1'b0};
        sig = '0;
        sig[0] = 1'b1;
        sig[5*W] = j.mode && j.code != 2'b10;
        return {sig, j.mode, j.code, 1'b1};
    endfunction
    function automatic job_t mk(logic m, logic [1:0] c, logic [SW-1:0] s);
        job_t j;
        j.mode = m;
        j.code = c;
        j.s = s;
        j.sig = SW'({$urandom(), $urandom(), $urandom()});
        return j;
    endfunction
    task automatic tick();
        job_t j;
        @(negedge i_clk);
        cyc++;
        i_rst = rst_req;
        i_ibm_valid = 1'b0;
        while (due.size() > 0 && due[0] < cyc) begin
            void'(due.pop_front());
            void'(dsig.pop_front());
        end
        if (due.size() > 0 && due[0] == cyc) begin
            i_ibm_valid = 1'b1;
            i_ibm_sigma = dsig.pop_front();
            void'(due.pop_front());
        end
        i_out_ready = $urandom_range(99) < rdy_pct;
        i_syn_valid = !rst_req && feed.size() > 0 && $urandom_range(99) < feed_pct;
        if (i_syn_valid) begin
            i_syn_mode = feed[0].mode;
            i_syn_code = feed[0].code;
            i_syn_S = feed[0].s;
        end
        #1;
        if (rst_req) begin
            expq.delete();
            issueq.delete();
            prev_outv = 0;
            return;
        end
        if (!o_syn_ready) saw_busy = 1;
        if (o_out_valid && !prev_outv) rise_cyc = cyc;
        prev_outv = o_out_valid;
        if (o_ibm_clear_and_wen) begin
            clrs.push_back(cyc);
            if (issueq.size() == 0) chk("issue_spurious", VW'(1), VW'(0));
            else begin
                j = issueq.pop_front();
                chk("issue", {o_ibm_S, o_ibm_mode, o_ibm_code, 1'b0}, {j.s, j.mode, j.code, 1'b0});
                if (!stub_dead) begin
                    due.push_back(cyc + (j.code == 2'b10 ? 8 : 4));
                    dsig.push_back(j.sig);
                end
            end
        end
        if (i_syn_valid && o_syn_ready) begin
            hs_cyc = cyc;
            j = feed.pop_front();
            expq.push_back(expect_of(j));
            if (!is_zero(j)) issueq.push_back(j);
        end
        if (o_out_valid && i_out_ready) begin
            pops.push_back(cyc);
            if (expq.size() == 0) chk("out_spurious", VW'(1), VW'(0));
            else chk("out", {o_out_sigma, o_out_mode, o_out_code, o_out_zero}, expq.pop_front());
        end
        if (o_err) begin
            err_cyc = cyc;
            if (!stub_dead) chk("unexpected_err", VW'(1), VW'(0));
            else if (expq.size() > 0) void'(expq.pop_front());
        end
    endtask
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((feed.size() > 0 || expq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", VW'(feed.size() + expq.size()), VW'(0));
    endtask
    initial begin
        int n, np, kind;
        logic [SW-1:0] s;
        i_rst = 1'b1;
        i_syn_valid = 1'b0;
        i_syn_mode = 1'b0;
        i_syn_code = '0;
        i_syn_S = '0;
        i_ibm_valid = 1'b0;
        i_ibm_sigma = '0;
        i_out_ready = 1'b0;
        repeat (2) tick();
        rst_req = 0;
        tick();
        chk("rst_syn_ready", VW'(o_syn_ready), VW'(1));
        chk("rst_out_valid", VW'(o_out_valid), VW'(0));
        chk("rst_err", VW'(o_err), VW'(0));
        chk("rst_clear", VW'(o_ibm_clear_and_wen), VW'(0));
        chk("rst_out_data", {o_out_sigma, o_out_mode, o_out_code, o_out_zero}, VW'(0));
        // T1 single t2 job
        feed.push_back(mk(1'b0, 2'b00, SW'(3)));
        drain(40);
        chk("t1_clear_lat", VW'(clrs[$] - hs_cyc), VW'(1));
        chk("t1_out_lat", VW'(rise_cyc - clrs[$]), VW'(5));
        // T2 all-zero bypass
        n = clrs.size();
        feed.push_back(mk(1'b0, 2'b10, '0));
        drain(40);
        chk("t2_no_clear", VW'(clrs.size()), VW'(n));
        chk("t2_lat", VW'(rise_cyc - hs_cyc), VW'(2));
        // T3 back-to-back t4 jobs chain with zero bubble
        feed.push_back(mk(1'b0, 2'b10, SW'(5)));
        feed.push_back(mk(1'b1, 2'b10, SW'(7) << 70));
        drain(60);
        chk("t3_chain", VW'(clrs[$] - clrs[clrs.size()-2]), VW'(8));
        chk("t3_gap", VW'(pops[$] - pops[pops.size()-2]), VW'(8));
        // T4 stalled consumer backs up into HOLD and staging
        rdy_pct = 0;
        saw_busy = 0;
        for (int i = 0; i < 3; i++) feed.push_back(mk(1'($urandom), 2'($urandom), SW'(i + 1)));
        repeat (20) tick();
        chk("t4_busy", VW'(saw_busy), VW'(1));
        rdy_pct = 100;
        drain(80);
        // T5 ibm never answers
        stub_dead = 1;
        err_cyc = -1;
        n = clrs.size();
        feed.push_back(mk(1'b0, 2'b00, SW'(9)));
        repeat (20) tick();
        if (clrs.size() > n) chk("t5_err_lat", VW'(err_cyc - clrs[n]), VW'(12));
        else chk("t5_issue", VW'(0), VW'(1));
        chk("t5_dropped", VW'(expq.size()), VW'(0));
        stub_dead = 0;
        feed.push_back(mk(1'b1, 2'b01, SW'(11)));
        drain(40);
        // T6 reset with a result pending and a job in flight
        rdy_pct = 0;
        feed.push_back(mk(1'b0, 2'b00, SW'(13)));
        feed.push_back(mk(1'b0, 2'b00, SW'(15)));
        repeat (7) tick();
        chk("t6_pending", VW'(o_out_valid), VW'(1));
        rst_req = 1;
        tick();
        rst_req = 0;
        rdy_pct = 100;
        tick();
        chk("t6_out_valid", VW'(o_out_valid), VW'(0));
        chk("t6_syn_ready", VW'(o_syn_ready), VW'(1));
        n = clrs.size();
        np = pops.size();
        repeat (6) tick();
        chk("t6_no_clear", VW'(clrs.size()), VW'(n));
        chk("t6_no_out", VW'(pops.size()), VW'(np));
        // Randomized traffic with back-pressure
        rdy_pct = 70;
        feed_pct = 60;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(3);
            s = SW'({$urandom(), $urandom(), $urandom()});
            if (kind == 0) s = '0;
            else if (kind == 1) s[4*W-1:0] = '0;
            feed.push_back(mk(1'($urandom), 2'($urandom), s));
        end
        drain(6000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
